// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel; fetch is master, memory is slave.
interface ifu_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush overrides push and pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC, credit-limited imem requests, prefetch FIFO, redirect.
// Define IFU_ALIGN_CHK_EN to trap misaligned redirects into a sticky FAULT state.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = ifu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  ifu_fetch_if.master        bus,
  output logic               if_id_valid,
  input  logic               if_id_ready,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  fetch_state_e    state, state_nxt;
  logic [31:0]     pc, pc_nxt;
  logic [CW-1:0]   outstanding, outst_nxt;
  logic [CW-1:0]   kill, kill_nxt;
  logic [CW:0]     inflight;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, push_entry;
  logic            req_fire, rsp_live, pop;
  logic [31:0]     redir_pc;
  logic            redir_misaligned;
  logic [31:0]     shadow [FIFO_DEPTH];
  logic [AW-1:0]   sh_wr, sh_rd;
  logic [31:0]     last_pc;
  logic            unused_full;

`ifdef IFU_ALIGN_CHK_EN
  assign redir_pc         = redirect_pc;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault      = (state == FAULT);
`else
  logic [1:0] unused_redir_lsb;
  assign unused_redir_lsb = redirect_pc[1:0];
  assign redir_pc         = {redirect_pc[31:2], 2'b00};
  assign redir_misaligned = 1'b0;
  assign fetch_fault      = 1'b0;
`endif

  // Credit counts every request not yet popped, including ones already marked for kill.
  assign inflight           = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req_valid = (state == RUN) && (inflight < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
  assign bus.imem_req_addr  = pc;

  assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_live   = bus.imem_rsp_valid && (kill == '0) && !redirect_valid;
  assign pop        = if_id_valid && if_id_ready && !redirect_valid;
  assign push_entry = '{instr: bus.imem_rsp_data, pc: shadow[sh_rd]};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    outst_nxt = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    kill_nxt  = kill;
    if (state == IDLE) state_nxt = RUN;
    if (req_fire) pc_nxt = pc + PC_STEP;
    if (bus.imem_rsp_valid && (kill != '0)) kill_nxt = kill - 1'b1;
    if (redirect_valid) begin
      pc_nxt    = redir_pc;
      outst_nxt = outstanding - CW'(bus.imem_rsp_valid);
      kill_nxt  = outstanding - CW'(bus.imem_rsp_valid);
      state_nxt = redir_misaligned ? FAULT : RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      sh_wr       <= '0;
      sh_rd       <= '0;
      last_pc     <= RESET_PC;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outst_nxt;
      kill        <= kill_nxt;
      if (redirect_valid) begin
        sh_wr <= '0;
        sh_rd <= '0;
      end else begin
        if (req_fire) sh_wr <= sh_wr + 1'b1;
        if (rsp_live) sh_rd <= sh_rd + 1'b1;
      end
      if (!fifo_empty) last_pc <= fifo_head.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) shadow[sh_wr] <= pc;
  end

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_live),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign unused_full = fifo_full;

  assign if_id_valid = !fifo_empty;
  assign if_id_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign if_id_pc    = fifo_empty ? last_pc : fifo_head.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order memory model and a PC scoreboard.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_id_valid, if_id_ready, fetch_fault, redirect_valid;
  logic [31:0] if_id_instr, if_id_pc, redirect_pc;
  logic        mem_ready;
  int unsigned lat;
  int unsigned cyc;
  int          vectors = 0;
  int          miscompares = 0;
  int          hs_total;
  logic [31:0] exp_pc;
  logic        bench_fault;
  logic [31:0] sb[$];
  logic [31:0] popped[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t memq[$];

  always #5 clk = ~clk;

  ifu_fetch_if bus();
  assign bus.imem_req_ready = mem_ready;

  ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .if_id_valid    (if_id_valid),
    .if_id_ready    (if_id_ready),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_if_valid", if_id_valid, 0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, RST_PC);
    chk("rst_fault", fetch_fault, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    popped.delete();
    repeat (2) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_pop(input string tag);
    for (int i = 0; i < 40 && popped.size() == 0; i++) @(negedge clk);
    chk(tag, popped.size() > 0, 1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    @(posedge clk); #1;
    popped.delete();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Memory: responds in order, lat cycles after the accepting edge.
  initial begin
    cyc = 0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!reset) begin
        memq.delete();
        bus.imem_rsp_valid = 1'b0;
      end else if (memq.size() > 0 && memq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor and scoreboard: each accepted request is expected to reach decode in order.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        exp_pc      = RST_PC;
        bench_fault = 1'b0;
        hs_total    = 0;
      end else begin
        chk("fault_flag", fetch_fault, bench_fault);
        if (redirect_valid) begin
          chk("req_cancel", bus.imem_req_valid, 0);
          sb.delete();
`ifdef IFU_ALIGN_CHK_EN
          bench_fault = (redirect_pc[1:0] != 2'b00);
          exp_pc      = redirect_pc;
`else
          exp_pc      = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_pc);
            memq.push_back('{bus.imem_req_addr, cyc + lat});
            sb.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            hs_total++;
          end
          if (if_id_valid) begin
            if (sb.size() == 0) begin
              chk("stale_valid", if_id_valid, 0);
            end else begin
              chk("head_pc", if_id_pc, sb[0]);
              chk("head_instr", if_id_instr, mem_word(sb[0]));
              if (if_id_ready) begin
                popped.push_back(if_id_pc);
                void'(sb.pop_front());
              end
            end
          end else begin
            chk("nop_instr", if_id_instr, NOP);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    if_id_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_ready      = 1'b1;
    lat            = 1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;

    // Streaming from reset: first instruction three edges after release.
    @(negedge clk); chk("t1_n0_valid", if_id_valid, 0);
    @(negedge clk); chk("t1_n1_valid", if_id_valid, 0);
    chk("t1_first_req", bus.imem_req_valid, 1);
    chk("t1_first_addr", bus.imem_req_addr, RST_PC);
    @(negedge clk); chk("t1_n2_valid", if_id_valid, 0);
    @(negedge clk); chk("t1_n3_valid", if_id_valid, 1);
    chk("t1_n3_pc", if_id_pc, RST_PC);
    repeat (20) @(negedge clk);
    chk("t1_progress", popped.size() >= 10, 1);
    for (int i = 0; i < 4; i++) chk("t1_seq", popped[i], 32'(4 * i));

    // Decode stall: credit caps requests at FIFO depth.
    if_id_ready = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    chk("t2_in_use", sb.size(), 2);
    chk("t2_req_drop", bus.imem_req_valid, 0);
    chk("t2_valid", if_id_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_pc_stable", if_id_pc, 32'h0);
      chk("t2_instr_stable", if_id_instr, mem_word(32'h0));
    end
    @(posedge clk); #1;
    if_id_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_pop_count", popped.size() >= 2, 1);
    chk("t2_pop0", popped[0], 32'h0);
    chk("t2_pop1", popped[1], 32'h4);

    // Memory backpressure: request at 0x8 held stable.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (hs_total >= 2) break;
    end
    chk("t3_sync", hs_total, 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_addr_hold", bus.imem_req_addr, 32'h8);
      if (i >= 1) chk("t3_valid_hold", bus.imem_req_valid, 1);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("t3_pop_count", popped.size() >= 3, 1);
    chk("t3_resume", popped[2], 32'h8);

    // Redirect with two responses still in flight.
    lat = 3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (memq.size() == 2) break;
    end
    chk("t4_inflight", memq.size(), 2);
    popped.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pop("t4_got_pop");
    chk("t4_first_pc", popped[0], 32'h100);

    // Redirect coinciding with a pop and a response.
    lat = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (if_id_valid && bus.imem_rsp_valid) break;
    end
    chk("t5_sync", if_id_valid && bus.imem_rsp_valid, 1);
    popped.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_empty", if_id_valid, 0);
    chk("t5_req", bus.imem_req_valid, 1);
    chk("t5_addr", bus.imem_req_addr, 32'h200);
    wait_pop("t5_got_pop");
    chk("t5_first_pc", popped[0], 32'h200);

    // Misaligned redirect.
`ifdef IFU_ALIGN_CHK_EN
    pulse_redirect(32'h102);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_fault", fetch_fault, 1);
      chk("t6_no_req", bus.imem_req_valid, 0);
      chk("t6_no_valid", if_id_valid, 0);
    end
    pulse_redirect(32'h200);
    @(negedge clk);
    chk("t6_fault_clr", fetch_fault, 0);
    wait_pop("t6_got_pop");
    chk("t6_first_pc", popped[0], 32'h200);
`else
    pulse_redirect(32'h102);
    @(negedge clk);
    chk("t6_fault_tied", fetch_fault, 0);
    wait_pop("t6_got_pop");
    chk("t6_first_pc", popped[0], 32'h100);
`endif
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
